// File: rtl/weight_loader_mem_fifo_ctrl.sv
// weight_loader_mem_fifo_ctrl
// FIFO controller wrapped around the m_axi buffer RAM (simple dual-port, registered
// read address and registered dout, so two edges from issue to valid data). Words
// are written straight into the RAM, read back through a two-stage in-flight
// tracker and parked in a 4-entry skid buffer so the consumer sees a zero-latency
// HLS-style empty_n/read interface and both sides can move one word per cycle.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   if_full_n/if_write  producer handshake, if_din write data
//   if_empty_n/if_read  consumer handshake, if_dout head-of-FIFO data
//   usedw               words held: RAM + in flight + skid
//   mem_*               buffer RAM control (clk_en/re tied high), mem_dout read data
module weight_loader_mem_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  mem_clk_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam int MEM_N = DEPTH - 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(MEM_N - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(MEM_N);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   mem_cnt;
  logic                  pipe0;
  logic                  pipe1;
  logic [DATA_WIDTH-1:0] skid_data [4];
  logic [1:0]            skid_head;
  logic [2:0]            skid_cnt;

  logic       wr;
  logic       iss;
  logic       pop;
  logic       push;
  logic [1:0] skid_tail;
  logic [2:0] reserved;

  // Handshakes are forced low while reset is asserted because the state
  // registers only clear on the next edge.
  assign if_full_n  = ~reset & (mem_cnt < CNT_FULL);
  assign if_empty_n = ~reset & (skid_cnt != 3'd0);

  assign wr   = if_write & if_full_n;
  assign pop  = if_read & if_empty_n;
  assign push = pipe1;

  // Skid slots already claimed: occupied entries plus reads still inside the RAM.
  // Issuing only while this is below 4 guarantees every returning word has a slot.
  assign reserved = skid_cnt + {2'b00, pipe0} + {2'b00, pipe1};
  assign iss      = (mem_cnt != '0) && (reserved < 3'd4);

  assign skid_tail = skid_head + skid_cnt[1:0];

  assign mem_clk_en = 1'b1;
  assign mem_re     = 1'b1;
  assign mem_we     = wr;
  assign mem_waddr  = wptr;
  assign mem_din    = if_din;
  assign mem_raddr  = rptr;

  assign if_dout = skid_data[skid_head];
  assign usedw   = mem_cnt + (ADDR_WIDTH + 1)'(pipe0) + (ADDR_WIDTH + 1)'(pipe1)
                 + (ADDR_WIDTH + 1)'(skid_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
    end else if (wr) begin
      wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr <= '0;
    end else if (iss) begin
      rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
    end
  end

  // mem_cnt only sees a write after its edge, so a read is never issued for a
  // word being written in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_cnt <= '0;
    end else begin
      case ({wr, iss})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

  // pipe0: RAM has latched the read address; pipe1: mem_dout is valid now.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe0 <= 1'b0;
      pipe1 <= 1'b0;
    end else begin
      pipe0 <= iss;
      pipe1 <= pipe0;
    end
  end

  // Skid payload has no reset; only the head/count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      skid_data[skid_tail] <= mem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_head <= 2'd0;
      skid_cnt  <= 3'd0;
    end else begin
      if (pop) begin
        skid_head <= skid_head + 2'd1;
      end
      case ({push, pop})
        2'b10:   skid_cnt <= skid_cnt + 3'd1;
        2'b01:   skid_cnt <= skid_cnt - 3'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader_mem_fifo_ctrl.sv
module tb_weight_loader_mem_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_full_n;
  logic        if_write = 1'b0;
  logic [31:0] if_din = 32'h0;
  logic        if_empty_n;
  logic        if_read = 1'b0;
  logic [31:0] if_dout;
  logic [6:0]  usedw;
  logic        mem_clk_en;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_din;
  logic        mem_re;
  logic [5:0]  mem_raddr;
  logic [31:0] mem_dout;

  int errors = 0;
  int checks = 0;
  int held = 0;
  logic [31:0] sb [$];

  weight_loader_mem_fifo_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(6),
    .DEPTH(63)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_full_n(if_full_n),
    .if_write(if_write),
    .if_din(if_din),
    .if_empty_n(if_empty_n),
    .if_read(if_read),
    .if_dout(if_dout),
    .usedw(usedw),
    .mem_clk_en(mem_clk_en),
    .mem_we(mem_we),
    .mem_waddr(mem_waddr),
    .mem_din(mem_din),
    .mem_re(mem_re),
    .mem_raddr(mem_raddr),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Buffer RAM model: registered read address, registered dout.
  logic [31:0] ram [0:63];
  logic [5:0]  raddr_q;
  always @(posedge clk) begin
    if (mem_clk_en) begin
      if (mem_we) ram[mem_waddr] <= mem_din;
      if (mem_re) begin
        raddr_q  <= mem_raddr;
        mem_dout <= ram[raddr_q];
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] din;
    logic        rd;
    logic        exp_full_n;
    logic        exp_empty_n;
    logic [6:0]  exp_usedw;
    logic        chk_dout;
    logic [31:0] exp_dout;
    logic        exp_we;
    logic [5:0]  exp_waddr;
  } vec_t;

  vec_t vecs [13];

  task automatic applyStimulus(input logic w, input logic [31:0] d, input logic r);
    @(posedge clk);
    #1;
    if_write = w;
    if_din   = d;
    if_read  = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle against the scoreboard; usedw must equal words accepted minus popped.
  task automatic runCycle(input logic w, input logic [31:0] d, input logic r,
                          output logic acc, output logic popped);
    applyStimulus(w, d, r);
    @(negedge clk);
    acc    = w & if_full_n;
    popped = 1'b0;
    checkOutput("usedw", {25'd0, usedw}, 32'(held));
    if (w && !if_full_n) checkOutput("we_while_full", {31'd0, mem_we}, 32'd0);
    if (acc) checkOutput("mem_din", mem_din, d);
    if (if_empty_n) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dout_unexpected: got 0x%0h expected no word", if_dout);
      end else begin
        checkOutput("dout_order", if_dout, sb[0]);
        if (r) begin
          void'(sb.pop_front());
          held--;
          popped = 1'b1;
        end
      end
    end
    if (acc) begin
      sb.push_back(d);
      held++;
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 32'hDEAD_0000, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_full_n", {31'd0, if_full_n}, 32'd0);
    checkOutput("rst_empty_n", {31'd0, if_empty_n}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    applyStimulus(1'b1, 32'hDEAD_0001, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    sb.delete();
    held = 0;
    @(negedge clk);
    checkOutput("post_rst_full_n", {31'd0, if_full_n}, 32'd1);
    checkOutput("post_rst_empty_n", {31'd0, if_empty_n}, 32'd0);
    checkOutput("post_rst_usedw", {25'd0, usedw}, 32'd0);
  endtask

  initial begin
    logic acc, popped, started;
    int wcnt, rcnt, gaps;

    vecs[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 32'h0,         1'b1, 6'd0};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 7'd1, 1'b0, 32'h0,         1'b0, 6'd1};
    vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 7'd1, 1'b0, 32'h0,         1'b0, 6'd1};
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 7'd1, 1'b0, 32'h0,         1'b0, 6'd1};
    vecs[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 7'd1, 1'b1, 32'hA5A5_0001, 1'b0, 6'd1};
    vecs[5]  = '{1'b1, 32'h11,        1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 32'h0,         1'b1, 6'd1};
    vecs[6]  = '{1'b1, 32'h22,        1'b0, 1'b1, 1'b0, 7'd1, 1'b0, 32'h0,         1'b1, 6'd2};
    vecs[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 7'd2, 1'b0, 32'h0,         1'b0, 6'd3};
    vecs[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 7'd2, 1'b0, 32'h0,         1'b0, 6'd3};
    vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 7'd2, 1'b1, 32'h11,        1'b0, 6'd3};
    vecs[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 7'd2, 1'b1, 32'h11,        1'b0, 6'd3};
    vecs[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 7'd1, 1'b1, 32'h22,        1'b0, 6'd3};
    vecs[12] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 32'h0,         1'b0, 6'd3};

    // Directed latency vectors
    doReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].din, vecs[i].rd);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_full_n", i), {31'd0, if_full_n}, {31'd0, vecs[i].exp_full_n});
      checkOutput($sformatf("vec%0d_empty_n", i), {31'd0, if_empty_n}, {31'd0, vecs[i].exp_empty_n});
      checkOutput($sformatf("vec%0d_usedw", i), {25'd0, usedw}, {25'd0, vecs[i].exp_usedw});
      checkOutput($sformatf("vec%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].exp_we});
      checkOutput($sformatf("vec%0d_waddr", i), {26'd0, mem_waddr}, {26'd0, vecs[i].exp_waddr});
      if (vecs[i].chk_dout) checkOutput($sformatf("vec%0d_dout", i), if_dout, vecs[i].exp_dout);
    end

    // Streaming 0..199 with consumer always ready
    doReset();
    wcnt = 0; rcnt = 0; gaps = 0; started = 1'b0;
    for (int c = 0; c < 400 && rcnt < 200; c++) begin
      runCycle(wcnt < 200, 32'(wcnt), 1'b1, acc, popped);
      if (acc) wcnt++;
      if (popped) begin
        rcnt++;
        started = 1'b1;
      end else if (started && rcnt < 200) begin
        gaps++;
      end
    end
    checkOutput("stream_count", 32'(rcnt), 32'd200);
    checkOutput("stream_gaps", 32'(gaps), 32'd0);

    // Fill with stalled consumer
    doReset();
    wcnt = 0;
    for (int c = 0; c < 80; c++) begin
      runCycle(1'b1, 32'(wcnt), 1'b0, acc, popped);
      if (acc) wcnt++;
    end
    checkOutput("full_accepted", 32'(wcnt), 32'd66);
    checkOutput("full_full_n", {31'd0, if_full_n}, 32'd0);
    checkOutput("full_usedw", {25'd0, usedw}, 32'd66);

    // Drain from full; RAM frees its first entry after the first issue
    rcnt = 0;
    for (int c = 0; c < 120 && rcnt < 66; c++) begin
      runCycle(1'b0, 32'h0, 1'b1, acc, popped);
      if (popped) rcnt++;
      if (c == 1) checkOutput("drain_full_n_c1", {31'd0, if_full_n}, 32'd0);
      if (c == 2) checkOutput("drain_full_n_c2", {31'd0, if_full_n}, 32'd1);
    end
    checkOutput("drain_count", 32'(rcnt), 32'd66);
    runCycle(1'b0, 32'h0, 1'b0, acc, popped);
    checkOutput("drain_empty_n", {31'd0, if_empty_n}, 32'd0);
    checkOutput("drain_usedw", {25'd0, usedw}, 32'd0);

    // Reset while words are stored and in flight
    doReset();
    for (int i = 0; i < 34; i++) runCycle(1'b1, 32'h3000 + 32'(i), 1'b0, acc, popped);
    for (int i = 0; i < 4; i++) runCycle(1'b0, 32'h0, 1'b0, acc, popped);
    runCycle(1'b0, 32'h0, 1'b1, acc, popped);
    runCycle(1'b0, 32'h0, 1'b1, acc, popped);
    runCycle(1'b0, 32'h0, 1'b0, acc, popped);
    doReset();
    for (int i = 0; i < 5; i++) runCycle(1'b1, 32'hBEEF_0000 + 32'(i), 1'b0, acc, popped);
    rcnt = 0;
    for (int c = 0; c < 30 && rcnt < 5; c++) begin
      runCycle(1'b0, 32'h0, 1'b1, acc, popped);
      if (popped) rcnt++;
    end
    checkOutput("rerun_count", 32'(rcnt), 32'd5);

    // Random handshakes
    doReset();
    for (int c = 0; c < 5000; c++) begin
      runCycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), acc, popped);
    end
    for (int c = 0; c < 200 && held > 0; c++) runCycle(1'b0, 32'h0, 1'b1, acc, popped);
    checkOutput("rand_drained", 32'(held), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
